mdu: RTL and testbench

//   Iterative multiply/divide unit with HI/LO registers. Consumes gpr read ports (rd1 -> a, rd2 -> b)
//   for MULT/MULTU/DIV/DIVU/MTHI/MTLO. HI/LO feed the write-back mux for MFHI/MFLO into gpr.

---
 rtl/mdu.sv | 172 +++++++++++++++++
 tb/tb_mdu.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: iterative radix-2 multiply/divide unit with HI/LO registers.
// Optional MDU_DIV0_FLAG_EN: divide by zero completes at once, sets sticky div0.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, nstate;

    logic [CW-1:0]      cnt;
    logic               last;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mq_n;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     acc_n;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               accept;
    logic               go;
    logic               mt;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quot_f;
    logic [WIDTH-1:0]   rem_f;

    assign accept = start && (state == IDLE) && !op[2];
    assign mt     = start && (state == IDLE) && (op[2:1] == 2'b10);

`ifdef MDU_DIV0_FLAG_EN
    logic dz;
    assign dz = op[1] && (b == '0);
    assign go = accept && !dz;
`else
    assign go   = accept;
    assign div0 = 1'b0;
`endif

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign a_neg = !op[0] && a[WIDTH-1];
    assign b_neg = !op[0] && b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // next-state logic
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (go)   nstate = RUN;
            RUN:  if (last) nstate = IDLE;
            default:        nstate = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == RUN);
    end

    // one iteration: shift-add for mult, restoring subtract for div
    always_comb begin
        acc_n   = acc;
        mq_n    = mq;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (is_div) begin
            shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
            diff    = shifted - {1'b0, d};
            if (shifted >= {1'b0, d}) begin
                acc_n = diff;
                mq_n  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted;
                mq_n  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum   = mq[0] ? acc + {1'b0, d} : acc;
            acc_n = {1'b0, sum[WIDTH:1]};
            mq_n  = {sum[0], mq[WIDTH-1:1]};
        end
    end

    // sign fixup on the magnitude results of the final iteration
    assign prod   = {acc_n[WIDTH-1:0], mq_n};
    assign prod_f = neg_q ? -prod : prod;
    assign quot_f = neg_q ? -mq_n : mq_n;
    assign rem_f  = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];

    // datapath, HI/LO and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            d      <= '0;
            acc    <= '0;
            mq     <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div0   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (go) begin
                is_div <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                d      <= abs_b;
                acc    <= '0;
                mq     <= abs_a;
                cnt    <= '0;
            end else if (mt) begin
                if (op[0]) lo <= a;
                else       hi <= a;
`ifdef MDU_DIV0_FLAG_EN
            end else if (accept) begin
                done <= 1'b1;
                div0 <= 1'b1;
`endif
            end else if (state == RUN) begin
                acc <= acc_n;
                mq  <= mq_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= rem_f;
                        lo <= quot_f;
                    end else begin
                        {hi, lo} <= prod_f;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for the mdu block.
// Expected HI/LO come from plain 64-bit arithmetic on the operands.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo),
        .div0 (div0)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h = '0;
        l = '0;
        case (o)
            3'd0: begin
                p = 64'(sx * sy);
                {h, l} = p;
            end
            3'd1: begin
                p = {32'h0, x} * {32'h0, y};
                {h, l} = p;
            end
            3'd2: begin
                if (y == 0) begin
                    l = x[31] ? 32'h1 : 32'hFFFF_FFFF;
                    h = x;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            3'd3: begin
                if (y == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = x;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    // Caller is at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int bc, output bit ok);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        bc = 0;
        ok = 1'b0;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 100; i++) begin
            if (busy) bc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({hi, lo, busy, done, div0} !== '0) begin
            fails++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b div0=%b, want all 0",
                     hi, lo, busy, done, div0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int bc;
        bit ok;
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, ok);
        tests++;
        if (!ok || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
            fails++;
            $display("FAIL multu_max: ok=%b hi=%h lo=%h, want fffffffe 00000001",
                     ok, hi, lo);
        end
        tests++;
        if (bc !== 32) begin
            fails++;
            $display("FAIL multu_busy: busy cycles %0d, want 32", bc);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_signed();
        int bc;
        bit ok;
        do_op(3'd0, -32'sd3, 32'd5, bc, ok);
        tests++;
        if (!ok || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            fails++;
            $display("FAIL mult_neg: hi=%h lo=%h, want ffffffff fffffff1", hi, lo);
        end
        do_op(3'd2, -32'sd7, 32'd2, bc, ok);
        tests++;
        if (!ok || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            fails++;
            $display("FAIL div_neg: hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
        end
        do_op(3'd3, 32'd100, 32'd7, bc, ok);
        tests++;
        if (!ok || hi !== 32'd2 || lo !== 32'd14) begin
            fails++;
            $display("FAIL divu: hi=%h lo=%h, want 00000002 0000000e", hi, lo);
        end
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, ok);
        tests++;
        if (!ok || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            fails++;
            $display("FAIL div_ovf: hi=%h lo=%h, want 00000000 80000000", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_mt();
        start = 1'b1;
        op = 3'd4;
        a = 32'h1234_5678;
        @(negedge clk);
        tests++;
        if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mthi: hi=%h busy=%b done=%b, want 12345678 0 0",
                     hi, busy, done);
        end
        op = 3'd5;
        a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b, want 12345678 9abcdef0 0",
                     hi, lo, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        bit ok;
        start = 1'b1;
        op = 3'd0;
        a = 32'd7;
        b = -32'sd9;
        @(negedge clk);
        op = 3'd5;
        a = 32'hDEAD_BEEF;
        @(negedge clk);
        op = 3'd0;
        a = 32'd100;
        b = 32'd100;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            fails++;
            $display("FAIL hold_run: busy=%b hi=%h lo=%h, want 1 12345678 9abcdef0",
                     busy, hi, lo);
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFC1) begin
            fails++;
            $display("FAIL busy_ignore: ok=%b hi=%h lo=%h, want ffffffff ffffffc1",
                     ok, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc;
        bit ok;
        do_op(3'd1, 32'h0001_0000, 32'h0001_0000, bc, ok);
        tests++;
        if (!ok || hi !== 32'h1 || lo !== 32'h0) begin
            fails++;
            $display("FAIL b2b_first: hi=%h lo=%h, want 00000001 00000000", hi, lo);
        end
        do_op(3'd2, 32'h7FFF_FFFF, -32'sd2, bc, ok);
        tests++;
        if (!ok || bc !== 32 || hi !== 32'h1 || lo !== 32'hC000_0001) begin
            fails++;
            $display("FAIL b2b_second: bc=%0d hi=%h lo=%h, want 32 00000001 c0000001",
                     bc, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_div0();
`ifdef MDU_DIV0_FLAG_EN
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = 32'h1111_2222;
        l0 = 32'h3333_4444;
        start = 1'b1;
        op = 3'd4;
        a = h0;
        @(negedge clk);
        op = 3'd5;
        a = l0;
        @(negedge clk);
        op = 3'd3;
        a = 32'd7;
        b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || div0 !== 1'b1 ||
            hi !== h0 || lo !== l0) begin
            fails++;
            $display("FAIL div0_flag: done=%b busy=%b div0=%b hi=%h lo=%h",
                     done, busy, div0, hi, lo);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b0 || div0 !== 1'b1) begin
            fails++;
            $display("FAIL div0_sticky: done=%b div0=%b, want 0 1", done, div0);
        end
`else
        int bc;
        bit ok;
        do_op(3'd3, 32'd7, 32'd0, bc, ok);
        tests++;
        if (!ok || bc !== 32 || lo !== 32'hFFFF_FFFF || hi !== 32'd7 ||
            div0 !== 1'b0) begin
            fails++;
            $display("FAIL divu0: bc=%0d hi=%h lo=%h div0=%b, want 32 7 ffffffff 0",
                     bc, hi, lo, div0);
        end
        do_op(3'd2, -32'sd7, 32'd0, bc, ok);
        tests++;
        if (!ok || lo !== 32'h1 || hi !== 32'hFFFF_FFF9) begin
            fails++;
            $display("FAIL div0_neg: hi=%h lo=%h, want fffffff9 00000001", hi, lo);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_abort();
        int bc;
        bit ok;
        bit seen;
        start = 1'b1;
        op = 3'd2;
        a = -32'sd1000;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || div0 !== 1'b0) begin
            fails++;
            $display("FAIL abort: busy=%b hi=%h lo=%h div0=%b, want all 0",
                     busy, hi, lo, div0);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_quiet: done/busy seen=%b after reset, want 0", seen);
        end
        do_op(3'd3, 32'd9, 32'd3, bc, ok);
        tests++;
        if (!ok || lo !== 32'd3 || hi !== 32'd0) begin
            fails++;
            $display("FAIL after_abort: hi=%h lo=%h, want 00000000 00000003", hi, lo);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int          bc;
        bit          ok;
        int          k;
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        mhi = $urandom;
        mlo = $urandom;
        start = 1'b1;
        op = 3'd4;
        a = mhi;
        @(negedge clk);
        op = 3'd5;
        a = mlo;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            x = rnd_val();
            y = rnd_val();
            if (k < 6) begin
                o = 3'($urandom_range(0, 3));
`ifdef MDU_DIV0_FLAG_EN
                if (o[1] && y == 0) y = 32'd1;
`endif
                model(o, x, y, mhi, mlo);
                do_op(o, x, y, bc, ok);
                tests++;
                if (!ok || bc !== 32 || hi !== mhi || lo !== mlo) begin
                    fails++;
                    $display("FAIL rand_op%0d: op=%0d a=%h b=%h bc=%0d got %h:%h want %h:%h",
                             n, o, x, y, bc, hi, lo, mhi, mlo);
                end
            end else begin
                o = (k < 8) ? 3'(4 + (k & 1)) : 3'(6 + (k & 1));
                if (o == 3'd4) mhi = x;
                if (o == 3'd5) mlo = x;
                start = 1'b1;
                op = o;
                a = x;
                b = y;
                @(negedge clk);
                start = 1'b0;
                tests++;
                if (busy !== 1'b0 || done !== 1'b0 || hi !== mhi || lo !== mlo) begin
                    fails++;
                    $display("FAIL rand_mt%0d: op=%0d busy=%b done=%b got %h:%h want %h:%h",
                             n, o, busy, done, hi, lo, mhi, mlo);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_div0();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
